fft_bitrev_out: RTL and testbench
=================================

Name: fft_bitrev_out

Overview:
- Output reorder buffer that sits directly downstream of the last FFT butterfly stage.
- Consumes the final stage's continuous complex stream, which arrives in bit-reversed frequency order, one sample per clock.
- Writes each frame into a ping-pong RAM at the bit-reversed address.
- Replays frames in natural bin order over a valid/ready interface to the spectrum consumer.

Parameters:
- DBW, 4: bits per real/imag component; a sample is {im, re}, 2*DBW bits.
- CBW, 3: log2 of frame length N = 1<<CBW; also the index/address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  2*DBW  sample from last stage, {im[2*DBW-1:DBW], re[DBW-1:0]}, signed.
- din_valid  in  1  din is valid this cycle. The stage pipeline cannot stall, so there is no ready.
- din_sof  in  1  qualifies din_valid; marks sample index 0 of a frame.
- dout  out  2*DBW  natural-order sample, same format as din.
- dout_valid  out  1  dout holds a valid sample.
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready.
- dout_last  out  1  dout is bin N-1 of the frame.
- ovf  out  1  one-cycle pulse: an incoming frame was dropped because no bank was free.
- sof_err  out  1  one-cycle pulse: din_sof seen mid-frame.

Behaviour:
- Storage: two banks of N x 2*DBW, addressed {bank, addr}. Each bank has a full flag. Memory contents are not reset.
- Write FSM, states W_IDLE and W_FILL; write index widx is CBW bits.
  - W_IDLE:
    - din_valid && din_sof and bank wbank not full: write din at bitrev(0)=0, widx<=1, go to W_FILL.
    - Same condition but wbank full: pulse ovf, stay in W_IDLE. The whole frame is dropped.
    - din_valid without sof: ignored.
  - W_FILL, on din_valid:
    - Write mem[wbank][bitrev(widx)] <= din, widx++.
    - If widx==N-1: set full[wbank], toggle wbank, widx<=0, go to W_IDLE.
    - If din_sof arrives while in W_FILL: pulse sof_err, write the sample at address 0 of the same bank, widx<=1. The frame restarts; the bank is not marked full.
    - din_valid low in W_FILL: hold state and widx (gaps allowed).
- bitrev(i): bit k of the address equals bit CBW-1-k of i.
- Read FSM, states R_IDLE, R_FETCH, R_RUN; read index ridx is CBW bits; read is a registered RAM read.
  - R_IDLE: when full[rbank], issue read of addr 0 and go to R_FETCH.
  - R_FETCH: load the output register and assert dout_valid. First dout_valid occurs exactly 2 cycles after the edge that set full.
  - R_RUN: on handshake, advance ridx and prefetch so throughput is 1 sample/cycle while dout_ready stays high.
  - dout, dout_valid and dout_last are held stable while dout_valid && !dout_ready. A skid entry is allowed; no sample may be lost or duplicated.
  - On handshake with dout_last=1: clear full[rbank] in that same cycle and toggle rbank. The freed bank is usable by the write FSM from the next cycle.
  - Back-to-back frames: if the other bank is already full, dout_valid may drop for at most 1 cycle between dout_last and the next bin 0.
- Simultaneous set of one bank's full flag and clear of the other's in the same cycle: both take effect.
- Reset mid-operation: all state is lost immediately.
  - Outputs go to dout=0, dout_valid=0, dout_last=0, ovf=0, sof_err=0.
  - full flags=0, wbank=rbank=0, widx=ridx=0, both FSMs to IDLE.
  - The first frame after reset requires din_sof.

Optional Feature:
- Macro: FFT_BITREV_OVF_CNT_EN.
- Defined:
  - Adds output port ovf_cnt, 8 bits.
  - Counts ovf pulses and saturates at 255.
  - Reset to 0 by rst_n only.
- Undefined:
  - Port and counter are absent.
  - ovf pulse behaviour is unchanged.

Test Plan:
- Frame order (DBW=4, CBW=3):
  - Stimulus: one frame of 8 consecutive samples, re=k, im=-k for k=0..7, sof on k=0, dout_ready=1.
  - Response: dout re order 0,4,2,6,1,5,3,7 with matching im; first valid 2 cycles after k=7 is written; dout_last only on re=7.
- Backpressure:
  - Stimulus: same frame, dout_ready toggled 1,0,0,1,...
  - Response: each value held while stalled; exactly 8 handshakes, same order, no duplicates.
- Overflow:
  - Stimulus: dout_ready=0, three back-to-back frames.
  - Response: frames 1-2 fill both banks; ovf pulses once at frame 3 sof.
  - Then raise dout_ready: frames 1 and 2 are output intact; ovf_cnt=1 with FFT_BITREV_OVF_CNT_EN.
- Early sof:
  - Stimulus: sof, 3 samples, then a new sof followed by 8 samples re=10..17.
  - Response: sof_err pulses once; the output frame is 10,14,12,16,11,15,13,17.
- Streaming:
  - Stimulus: 4 continuous frames, dout_ready=1.
  - Response: all 32 samples output; ovf never asserts; bank ping-pong is continuous.
- Reset mid-read:
  - Stimulus: assert rst_n=0 after 3 output handshakes.
  - Response: all outputs 0 immediately.
  - After release: a new frame outputs correctly, with no residue of the old frame.

Source files
------------

// File: rtl/fft_bitrev_out.sv
// Reorders a bit-reversed FFT output stream into natural bin order through a ping-pong RAM.
// Optional saturating drop counter on port ovf_cnt when FFT_BITREV_OVF_CNT_EN is defined.
module fft_bitrev_out #(
    parameter int DBW = 4,
    parameter int CBW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2*DBW-1:0] din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic [2*DBW-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic             ovf,
    output logic             sof_err
`ifdef FFT_BITREV_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_cnt
`endif
);

    localparam int N  = 1 << CBW;
    localparam int SW = 2 * DBW;
    localparam logic [CBW-1:0] IDX_LAST = '1;

    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RUN} r_state_t;

    function automatic logic [CBW-1:0] bitrev(input logic [CBW-1:0] i);
        logic [CBW-1:0] r;
        for (int k = 0; k < CBW; k++) r[k] = i[CBW-1-k];
        return r;
    endfunction

    logic [SW-1:0] mem [2*N];

    w_state_t       w_state, w_state_n;
    logic [CBW-1:0] widx, widx_n;
    logic           wbank, wbank_n;
    logic           wr_en, set_full, ovf_n, sof_err_n;
    logic [CBW-1:0] wr_addr;

    r_state_t       r_state, r_state_n;
    logic [CBW-1:0] ridx, ridx_n, iidx;
    logic           rbank, rbank_n, ibank;
    logic           rd_done, rd_done_n;
    logic           issue, clr_full;
    logic [1:0]     full, full_n;

    // Stage 1 is the registered RAM read; stage 2 is the output register.
    logic [SW-1:0]  s1_data;
    logic           s1_vld, s1_last;
    logic           hs, s2_load, s1_free;

    assign hs      = dout_valid && dout_ready;
    assign s2_load = s1_vld && (!dout_valid || dout_ready);
    assign s1_free = !s1_vld || s2_load;

    always_comb begin
        w_state_n = w_state;
        widx_n    = widx;
        wbank_n   = wbank;
        wr_en     = 1'b0;
        wr_addr   = '0;
        set_full  = 1'b0;
        ovf_n     = 1'b0;
        sof_err_n = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (din_valid && din_sof) begin
                    if (full[wbank]) begin
                        ovf_n = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        widx_n    = CBW'(1);
                        w_state_n = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (din_valid) begin
                    wr_en = 1'b1;
                    if (din_sof) begin
                        // Restart the frame in the same bank.
                        sof_err_n = 1'b1;
                        widx_n    = CBW'(1);
                    end else begin
                        wr_addr = bitrev(widx);
                        widx_n  = widx + 1'b1;
                        if (widx == IDX_LAST) begin
                            set_full  = 1'b1;
                            wbank_n   = ~wbank;
                            widx_n    = '0;
                            w_state_n = W_IDLE;
                        end
                    end
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_n = r_state;
        ridx_n    = ridx;
        rbank_n   = rbank;
        rd_done_n = rd_done;
        issue     = 1'b0;
        iidx      = ridx;
        ibank     = rbank;
        clr_full  = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (full[rbank]) begin
                    issue     = 1'b1;
                    iidx      = '0;
                    ridx_n    = CBW'(1);
                    rd_done_n = 1'b0;
                    r_state_n = R_FETCH;
                end
            end
            R_FETCH, R_RUN: begin
                if (r_state == R_FETCH) r_state_n = R_RUN;
                if (s1_free && !rd_done) begin
                    issue  = 1'b1;
                    ridx_n = ridx + 1'b1;
                    if (ridx == IDX_LAST) rd_done_n = 1'b1;
                end
                if (hs && dout_last) begin
                    clr_full  = 1'b1;
                    rbank_n   = ~rbank;
                    ridx_n    = '0;
                    rd_done_n = 1'b0;
                    r_state_n = R_IDLE;
                    // Start the other bank on the same edge to keep the frame gap to one cycle.
                    if (full[~rbank]) begin
                        issue     = 1'b1;
                        ibank     = ~rbank;
                        iidx      = '0;
                        ridx_n    = CBW'(1);
                        r_state_n = R_FETCH;
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        full_n = full;
        if (set_full) full_n[wbank] = 1'b1;
        if (clr_full) full_n[rbank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            widx    <= '0;
            wbank   <= 1'b0;
            r_state <= R_IDLE;
            ridx    <= '0;
            rbank   <= 1'b0;
            rd_done <= 1'b0;
            full    <= 2'b00;
            ovf     <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            w_state <= w_state_n;
            widx    <= widx_n;
            wbank   <= wbank_n;
            r_state <= r_state_n;
            ridx    <= ridx_n;
            rbank   <= rbank_n;
            rd_done <= rd_done_n;
            full    <= full_n;
            ovf     <= ovf_n;
            sof_err <= sof_err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank, wr_addr}] <= din;
        if (issue) s1_data <= mem[{ibank, iidx}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            if (issue) begin
                s1_vld  <= 1'b1;
                s1_last <= (iidx == IDX_LAST);
            end else if (s2_load) begin
                s1_vld  <= 1'b0;
            end
            if (s2_load) begin
                dout       <= s1_data;
                dout_valid <= 1'b1;
                dout_last  <= s1_last;
            end else if (hs) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end
    end

`ifdef FFT_BITREV_OVF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (ovf_n && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_out.sv
// Bench for fft_bitrev_out: directed scenarios with random sample data, natural-order
// reference frames kept in an expected queue, handshake monitor on the falling edge.
module tb_fft_bitrev_out;

    localparam int DBW = 4;
    localparam int CBW = 3;
    localparam int N   = 1 << CBW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2*DBW-1:0] din;
    logic             din_valid;
    logic             din_sof;
    logic [2*DBW-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             ovf;
    logic             sof_err;
`ifdef FFT_BITREV_OVF_CNT_EN
    logic [7:0]       ovf_cnt;
`endif

    fft_bitrev_out #(.DBW(DBW), .CBW(CBW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_sof    (din_sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .ovf        (ovf),
        .sof_err    (sof_err)
`ifdef FFT_BITREV_OVF_CNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ovf_seen = 0;
    int sof_err_seen = 0;
    int hs_cyc[$];
    logic [2*DBW:0] exp_q[$];
    logic [2*DBW:0] e;
    logic [2*DBW-1:0] frame [N];
    logic prev_stall = 1'b0;
    logic [2*DBW-1:0] prev_dout;
    logic prev_last;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: output bin j is the j-th natural-order bin, which arrived as sample bitrev(j)
    function automatic int bitrev(input int i);
        int r = 0;
        for (int b = 0; b < CBW; b++) r = r * 2 + ((i >> b) & 1);
        return r;
    endfunction

    task automatic expect_frame();
        for (int j = 0; j < N; j++) exp_q.push_back({(j == N - 1), frame[bitrev(j)]});
    endtask

    task automatic rand_frame();
        for (int k = 0; k < N; k++) frame[k] = 8'($urandom);
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int gap);
        for (int k = 0; k < N; k++) begin
            din       = frame[k];
            din_valid = 1'b1;
            din_sof   = (k == 0);
            step();
        end
        din_valid = 1'b0;
        din_sof   = 1'b0;
        repeat (gap) step();
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0, 2: random ready
    task automatic drain(input int mode, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            case (mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = (n % 3 == 0);
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(dout_valid), 1);
                check("hold_data", 32'(dout), 32'(prev_dout));
                check("hold_last", 32'(dout_last), 32'(prev_last));
            end
            if (ovf) ovf_seen++;
            if (sof_err) sof_err_seen++;
            if (dout_valid && dout_ready) begin
                check("q_nonempty", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data", 32'(dout), 32'(e[2*DBW-1:0]));
                    check("last", 32'(dout_last), 32'(e[2*DBW]));
                end
                hs_cyc.push_back(cyc);
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        din_sof    = 1'b0;
        dout_ready = 1'b0;
        repeat (3) step();
        check("rst_dout", 32'(dout), 0);
        check("rst_valid", 32'(dout_valid), 0);
        check("rst_last", 32'(dout_last), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_sof_err", 32'(sof_err), 0);
`ifdef FFT_BITREV_OVF_CNT_EN
        check("rst_ovf_cnt", 32'(ovf_cnt), 0);
`endif
        rst_n = 1'b1;
        step();

        // frame order and first-valid latency
        dout_ready = 1'b1;
        for (int k = 0; k < N; k++) frame[k] = {4'(-k), 4'(k)};
        expect_frame();
        hs_cyc.delete();
        send_frame(0);
        @(negedge clk);
        check("lat_e0", 32'(dout_valid), 0);
        @(negedge clk);
        check("lat_e1", 32'(dout_valid), 0);
        @(negedge clk);
        check("lat_e2", 32'(dout_valid), 1);
        step();
        drain(0, 50);
        check("t1_count", hs_cyc.size(), 8);
        if (hs_cyc.size() == 8) check("t1_span", hs_cyc[7] - hs_cyc[0], 7);

        // backpressure 1,0,0
        dout_ready = 1'b0;
        expect_frame();
        hs_cyc.delete();
        send_frame(0);
        drain(1, 100);
        check("t2_count", hs_cyc.size(), 8);
        repeat (3) step();
        check("t2_idle", 32'(dout_valid), 0);

        // overflow: three frames with consumer stalled
        ovf_seen     = 0;
        sof_err_seen = 0;
        dout_ready   = 1'b0;
        rand_frame(); expect_frame(); send_frame(0);
        rand_frame(); expect_frame(); send_frame(0);
        rand_frame(); send_frame(0);
        repeat (2) step();
        check("t3_ovf", ovf_seen, 1);
        check("t3_sof_err", sof_err_seen, 0);
        hs_cyc.delete();
        drain(0, 100);
        check("t3_count", hs_cyc.size(), 16);
        if (hs_cyc.size() == 16) check("t3_gap_ok", 32'((hs_cyc[8] - hs_cyc[7]) <= 2), 1);
`ifdef FFT_BITREV_OVF_CNT_EN
        check("t3_ovf_cnt", 32'(ovf_cnt), 1);
`endif
        repeat (3) step();
        check("t3_idle", 32'(dout_valid), 0);

        // early sof restarts the frame
        ovf_seen     = 0;
        sof_err_seen = 0;
        dout_ready   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din       = 8'($urandom);
            din_valid = 1'b1;
            din_sof   = (k == 0);
            step();
        end
        for (int k = 0; k < N; k++) frame[k] = {4'(-(10 + k)), 4'(10 + k)};
        expect_frame();
        hs_cyc.delete();
        send_frame(0);
        drain(2, 300);
        check("t4_sof_err", sof_err_seen, 1);
        check("t4_ovf", ovf_seen, 0);
        check("t4_count", hs_cyc.size(), 8);

        // streaming four frames
        ovf_seen   = 0;
        dout_ready = 1'b1;
        hs_cyc.delete();
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            expect_frame();
            send_frame(3);
        end
        drain(0, 100);
        check("t5_count", hs_cyc.size(), 32);
        check("t5_ovf", ovf_seen, 0);

        // reset after three output handshakes
        dout_ready = 1'b0;
        rand_frame();
        expect_frame();
        send_frame(0);
        hs_cyc.delete();
        dout_ready = 1'b1;
        for (int i = 0; i < 50 && hs_cyc.size() < 3; i++) step();
        check("t6_hs3", hs_cyc.size(), 3);
        rst_n = 1'b0;
        #1;
        check("t6_dout", 32'(dout), 0);
        check("t6_valid", 32'(dout_valid), 0);
        check("t6_last", 32'(dout_last), 0);
        check("t6_ovf", 32'(ovf), 0);
        check("t6_sof_err", 32'(sof_err), 0);
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            din       = 8'($urandom);
            din_valid = 1'b1;
            din_sof   = 1'b0;
            step();
        end
        din_valid = 1'b0;
        step();
        check("t6_no_sof_ignored", 32'(dout_valid), 0);
        rand_frame();
        expect_frame();
        hs_cyc.delete();
        send_frame(0);
        drain(2, 300);
        check("t6_count", hs_cyc.size(), 8);
        repeat (3) step();
        check("t6_idle", 32'(dout_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
